mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: PRIO_INIT, default 0, index of the port (0=A, 1=B) that holds priority after reset.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 REQ_A, REQ_B  input  1 each  request; held high, command stable, until that port's ACK.
REQ-005 WR_A, WR_B  input  1 each  1=write, 0=read.
REQ-006 ADDR_A, ADDR_B  input  2 each  word address 0..3.
REQ-007 WD_A, WD_B  input  3 each  write data.
REQ-008 ACK_A, ACK_B  output  1 each  one-cycle completion pulse.
REQ-009 RD_A, RD_B  output  3 each  read data; updated only on that port's read completion.
REQ-010 BUSY  output  1  high in every non-IDLE state.
REQ-011 OWNER  output  1  port being served; meaningful only while BUSY.
REQ-012 MSEL  output  2  memory word select.
REQ-013 MD  output  3  memory write data.
REQ-014 ME  output  1  memory write enable (level-sensitive latch enable).
REQ-015 MQ  input  3  memory read data.

Function
REQ-016 States SHALL be IDLE, SETUP, STROBE, HOLD, RSEL, RCAP, DONE; all outputs registered or decoded from state/registers only, never combinational from REQ_x.
REQ-017 IDLE, rising edge with any REQ_x high: SHALL latch winner's WR, ADDR, WD and OWNER; go to SETUP if WR=1, else RSEL.
REQ-018 Arbitration: one request -> that port served regardless of priority; both -> priority port served; after every grant priority SHALL pass to the other port.
REQ-019 Write sequence: SETUP -> STROBE -> HOLD -> DONE -> IDLE, one cycle each; ACK at 4th cycle after accept edge.
REQ-020 MSEL and MD SHALL equal latched ADDR/WD throughout SETUP, STROBE, HOLD; ME=1 only in STROBE, 0 in every other state.
REQ-021 Read sequence: RSEL -> RCAP -> DONE -> IDLE; MSEL=latched ADDR in RSEL and RCAP; ME=0.
REQ-022 On the edge leaving RCAP, MQ SHALL be loaded into RD_<OWNER>; the other port's RD unchanged.
REQ-023 DONE: ACK_<OWNER>=1 for exactly that cycle; other ACK 0; RD valid in DONE and held until that port's next read completes.
REQ-024 DONE SHALL not accept requests; REQ sampled in the following IDLE cycle is treated as a new command.
REQ-025 Changes to REQ/WR/ADDR/WD of any port while BUSY SHALL not affect the transaction in progress.
REQ-026 Back-to-back: both ports requesting continuously SHALL alternate A,B,A,B... with one IDLE cycle between transactions.
REQ-027 MSEL and MD SHALL hold their last values in IDLE and DONE (no glitch while ME=0).

Reset
REQ-028 RST high at an edge: state IDLE, ME=0, MSEL=0, MD=0, ACK_A=ACK_B=0, RD_A=RD_B=0, BUSY=0, OWNER=0, priority=PRIO_INIT; overrides all other events.
REQ-029 Reset mid-transaction SHALL abort with no ACK; if in STROBE, ME SHALL be 0 from the next cycle; target word contents then undefined.

Verification
REQ-030 Reset, then REQ_A write ADDR=2 WD=5 -> ME high exactly one cycle with MSEL=2 MD=5 stable from SETUP..HOLD, ACK_A at accept+4.
REQ-031 After REQ-030, REQ_B read ADDR=2 (memory model returns 5) -> ACK_B at accept+3, RD_B=5, RD_A unchanged 0, ME never high.
REQ-032 PRIO_INIT=0, REQ_A and REQ_B both raised same cycle, held -> order A,B,A,B; OWNER matches each ACK.
REQ-033 PRIO_INIT=1, simultaneous requests -> B served first.
REQ-034 RST asserted during STROBE of a write -> next cycle ME=0, BUSY=0, no ACK; subsequent request served normally.
REQ-035 Change ADDR_A from 1 to 3 during an A write to 1 -> MSEL stays 1 through HOLD; word 3 untouched.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port arbiter that serialises read and write commands onto one
// latch-enabled memory word interface.
module mem_arbiter #(
    parameter int unsigned PRIO_INIT = 0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       REQ_A,
    input  logic       REQ_B,
    input  logic       WR_A,
    input  logic       WR_B,
    input  logic [1:0] ADDR_A,
    input  logic [1:0] ADDR_B,
    input  logic [2:0] WD_A,
    input  logic [2:0] WD_B,
    output logic       ACK_A,
    output logic       ACK_B,
    output logic [2:0] RD_A,
    output logic [2:0] RD_B,
    output logic       BUSY,
    output logic       OWNER,
    output logic [1:0] MSEL,
    output logic [2:0] MD,
    output logic       ME,
    input  logic [2:0] MQ
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SETUP  = 3'd1;
    localparam logic [2:0] STROBE = 3'd2;
    localparam logic [2:0] HOLD   = 3'd3;
    localparam logic [2:0] RSEL   = 3'd4;
    localparam logic [2:0] RCAP   = 3'd5;
    localparam logic [2:0] DONE   = 3'd6;

    localparam logic PRIO_RST = (PRIO_INIT != 0);

    logic [2:0] state_q, state_d;
    logic       owner_q, owner_d;
    logic       prio_q, prio_d;
    logic [1:0] sel_q, sel_d;
    logic [2:0] md_q, md_d;
    logic [2:0] rda_q, rda_d;
    logic [2:0] rdb_q, rdb_d;
    logic       grant_b;

    // B wins when alone, or when both request and B holds priority
    assign grant_b = REQ_B && (!REQ_A || prio_q);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        prio_d  = prio_q;
        sel_d   = sel_q;
        md_d    = md_q;
        rda_d   = rda_q;
        rdb_d   = rdb_q;
        unique case (state_q)
            IDLE: begin
                if (REQ_A || REQ_B) begin
                    owner_d = grant_b;
                    prio_d  = !grant_b;
                    sel_d   = grant_b ? ADDR_B : ADDR_A;
                    md_d    = grant_b ? WD_B : WD_A;
                    state_d = (grant_b ? WR_B : WR_A) ? SETUP : RSEL;
                end
            end
            SETUP:  state_d = STROBE;
            STROBE: state_d = HOLD;
            HOLD:   state_d = DONE;
            RSEL:   state_d = RCAP;
            RCAP: begin
                state_d = DONE;
                if (owner_q) rdb_d = MQ;
                else         rda_d = MQ;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            prio_q  <= PRIO_RST;
            sel_q   <= 2'd0;
            md_q    <= 3'd0;
            rda_q   <= 3'd0;
            rdb_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
            sel_q   <= sel_d;
            md_q    <= md_d;
            rda_q   <= rda_d;
            rdb_q   <= rdb_d;
        end
    end

    assign ME    = (state_q == STROBE);
    assign BUSY  = (state_q != IDLE);
    assign ACK_A = (state_q == DONE) && !owner_q;
    assign ACK_B = (state_q == DONE) && owner_q;
    assign OWNER = owner_q;
    assign MSEL  = sel_q;
    assign MD    = md_q;
    assign RD_A  = rda_q;
    assign RD_B  = rdb_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, corner sequences and
// randomized traffic against a transaction-level reference model.
module tb_mem_arbiter;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       RST;
    logic [1:0] req, wr;
    logic [1:0] addr [2];
    logic [2:0] wd [2];

    logic       ack_a, ack_b, busy, owner, me;
    logic [2:0] rd_a, rd_b, md, mq;
    logic [1:0] msel;

    logic       ack_a1, ack_b1, busy1, owner1, me1;
    logic [2:0] rd_a1, rd_b1, md1;
    logic [1:0] msel1;

    logic [2:0] tbmem [4] = '{default: 3'd0};
    assign mq = tbmem[msel];
    always @(posedge CLK) if (me) tbmem[msel] <= md;

    int total = 0;
    int bad = 0;

    mem_arbiter #(.PRIO_INIT(0)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_A(req[0]), .REQ_B(req[1]), .WR_A(wr[0]), .WR_B(wr[1]),
        .ADDR_A(addr[0]), .ADDR_B(addr[1]), .WD_A(wd[0]), .WD_B(wd[1]),
        .ACK_A(ack_a), .ACK_B(ack_b), .RD_A(rd_a), .RD_B(rd_b),
        .BUSY(busy), .OWNER(owner), .MSEL(msel), .MD(md), .ME(me),
        .MQ(mq)
    );

    mem_arbiter #(.PRIO_INIT(1)) dut1 (
        .CLK(CLK), .RST(RST),
        .REQ_A(req[0]), .REQ_B(req[1]), .WR_A(wr[0]), .WR_B(wr[1]),
        .ADDR_A(addr[0]), .ADDR_B(addr[1]), .WD_A(wd[0]), .WD_B(wd[1]),
        .ACK_A(ack_a1), .ACK_B(ack_b1), .RD_A(rd_a1), .RD_B(rd_b1),
        .BUSY(busy1), .OWNER(owner1), .MSEL(msel1), .MD(md1), .ME(me1),
        .MQ(3'd0)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic gack(input int p);
        return p != 0 ? ack_b : ack_a;
    endfunction

    function automatic logic [2:0] grd(input int p);
        return p != 0 ? rd_b : rd_a;
    endfunction

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        req = 2'b00;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    // one transaction from idle; chg scrambles the command after accept
    task automatic run_txn(input int p, input bit w, input logic [1:0] a,
                           input logic [2:0] d, input logic [2:0] erd,
                           input bit chg, input string nm);
        logic [2:0] other_rd, untouched;
        int k, me_n;
        bit got;
        @(negedge CLK);
        other_rd  = grd(1 - p);
        untouched = tbmem[a ^ 2'd2];
        wr[p] = w;
        addr[p] = a;
        wd[p] = d;
        req[p] = 1'b1;
        k = 0;
        me_n = 0;
        got = 1'b0;
        while (!got && k < 12) begin
            @(negedge CLK);
            k++;
            if (chg && k == 1) begin
                addr[p] = a ^ 2'd2;
                wd[p] = ~d;
            end
            if (me) me_n++;
            if (w && k <= 3) begin
                chk({nm, "_msel"}, msel, a);
                chk({nm, "_md"}, md, d);
            end
            if (gack(p)) begin
                got = 1'b1;
                req[p] = 1'b0;
                chk({nm, "_lat"}, k, w ? 4 : 3);
                chk({nm, "_oack"}, gack(1 - p), 0);
                chk({nm, "_owner"}, owner, p);
                if (!w) chk({nm, "_rd"}, grd(p), erd);
                chk({nm, "_ord"}, grd(1 - p), other_rd);
            end
        end
        chk({nm, "_acked"}, got, 1);
        chk({nm, "_me_cnt"}, me_n, w ? 1 : 0);
        if (w) chk({nm, "_mem"}, tbmem[a], d);
        if (chg) chk({nm, "_untouched"}, tbmem[a ^ 2'd2], untouched);
    endtask

    typedef struct {
        int         p;
        bit         w;
        logic [1:0] a;
        logic [2:0] d;
        logic [2:0] erd;
        bit         chg;
        string      nm;
    } vec_t;

    vec_t tbl [8];

    task automatic alt_test();
        int n, c, last;
        bit u1seen;
        do_reset();
        wr = 2'b00;
        addr[0] = 2'd2;
        addr[1] = 2'd0;
        req = 2'b11;
        n = 0;
        c = 0;
        last = 0;
        u1seen = 1'b0;
        while (n < 4 && c < 40) begin
            @(negedge CLK);
            c++;
            if (!u1seen && (ack_a1 || ack_b1)) begin
                u1seen = 1'b1;
                chk("prio1_first_b", ack_b1, 1);
                chk("prio1_first_a", ack_a1, 0);
            end
            if (ack_a || ack_b) begin
                chk("alt_order", ack_b, n % 2);
                chk("alt_owner", owner, ack_b);
                if (n > 0) chk("alt_gap", c - last, 4);
                else chk("alt_first", c, 3);
                last = c;
                n++;
            end
        end
        chk("alt_count", n, 4);
        chk("prio1_seen", u1seen, 1);
        req = 2'b00;
        repeat (4) @(negedge CLK);
    endtask

    task automatic rst_strobe_test();
        int k;
        do_reset();
        wr[0] = 1'b1;
        addr[0] = 2'd1;
        wd[0] = 3'd4;
        req[0] = 1'b1;
        k = 0;
        while (!me && k < 8) begin
            @(negedge CLK);
            k++;
            chk("abort_noack", ack_a, 0);
        end
        chk("abort_reached_strobe", me, 1);
        RST = 1'b1;
        req = 2'b00;
        @(negedge CLK);
        chk("abort_me", me, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ack", {ack_a, ack_b}, 0);
        RST = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            chk("abort_quiet", {ack_a, ack_b, busy}, 0);
        end
        run_txn(0, 1, 2'd0, 3'd3, 3'd0, 0, "post_wr");
        run_txn(1, 0, 2'd0, 3'd0, 3'd3, 0, "post_rd");
    endtask

    task automatic rand_test(input int ncyc);
        bit         m_idle, m_prio, m_own, m_wr, e_ack, win;
        int         m_cnt, m_len;
        logic [1:0] m_addr, m_sel;
        logic [2:0] m_rd [2];
        logic [2:0] mem_m [4];
        do_reset();
        m_idle = 1'b1;
        m_prio = 1'b0;
        m_own = 1'b0;
        m_wr = 1'b0;
        m_cnt = 0;
        m_len = 0;
        m_addr = 2'd0;
        m_sel = 2'd0;
        m_rd[0] = 3'd0;
        m_rd[1] = 3'd0;
        for (int i = 0; i < 4; i++) mem_m[i] = tbmem[i];
        for (int c = 0; c < ncyc; c++) begin
            e_ack = !m_idle && m_cnt == m_len;
            chk("r_busy", busy, !m_idle);
            chk("r_ack_a", ack_a, e_ack && !m_own);
            chk("r_ack_b", ack_b, e_ack && m_own);
            chk("r_me", me, !m_idle && m_wr && m_cnt == 2);
            chk("r_rd_a", rd_a, m_rd[0]);
            chk("r_rd_b", rd_b, m_rd[1]);
            chk("r_msel", msel, m_sel);
            if (!m_idle) chk("r_owner", owner, m_own);
            if (e_ack && m_wr) chk("r_mem", tbmem[m_addr], mem_m[m_addr]);
            for (int p = 0; p < 2; p++) begin
                if (e_ack && m_own == p) req[p] = 1'b0;
                if (!req[p] && $urandom_range(0, 1) == 1) begin
                    wr[p] = 1'($urandom_range(0, 1));
                    addr[p] = 2'($urandom_range(0, 3));
                    wd[p] = 3'($urandom_range(0, 7));
                    req[p] = 1'b1;
                end
            end
            if (m_idle) begin
                if (req != 2'b00) begin
                    win = (req == 2'b11) ? m_prio : req[1];
                    m_own = win;
                    m_prio = !win;
                    m_wr = wr[win];
                    m_addr = addr[win];
                    m_sel = addr[win];
                    m_len = m_wr ? 4 : 3;
                    m_cnt = 1;
                    m_idle = 1'b0;
                    if (m_wr) mem_m[m_addr] = wd[win];
                end
            end else if (m_cnt == m_len) begin
                m_idle = 1'b1;
            end else begin
                m_cnt++;
                if (!m_wr && m_cnt == m_len) m_rd[m_own] = mem_m[m_addr];
            end
            @(negedge CLK);
        end
        req = 2'b00;
        repeat (6) @(negedge CLK);
    endtask

    initial begin
        RST = 1'b1;
        req = 2'b00;
        wr = 2'b00;
        addr[0] = 2'd0;
        addr[1] = 2'd0;
        wd[0] = 3'd0;
        wd[1] = 3'd0;

        tbl[0] = '{0, 1'b1, 2'd2, 3'd5, 3'd0, 1'b0, "wrA2"};
        tbl[1] = '{1, 1'b0, 2'd2, 3'd0, 3'd5, 1'b0, "rdB2"};
        tbl[2] = '{1, 1'b1, 2'd0, 3'd7, 3'd0, 1'b0, "wrB0"};
        tbl[3] = '{0, 1'b0, 2'd0, 3'd0, 3'd7, 1'b0, "rdA0"};
        tbl[4] = '{0, 1'b1, 2'd1, 3'd6, 3'd0, 1'b1, "wrA1chg"};
        tbl[5] = '{1, 1'b0, 2'd1, 3'd0, 3'd6, 1'b0, "rdB1"};
        tbl[6] = '{1, 1'b0, 2'd3, 3'd0, 3'd0, 1'b0, "rdB3"};
        tbl[7] = '{0, 1'b0, 2'd2, 3'd0, 3'd5, 1'b0, "rdA2"};

        do_reset();
        chk("rst_busy", busy, 0);
        chk("rst_me", me, 0);
        chk("rst_msel", msel, 0);
        chk("rst_md", md, 0);
        chk("rst_ack", {ack_a, ack_b}, 0);
        chk("rst_rd_a", rd_a, 0);
        chk("rst_rd_b", rd_b, 0);
        chk("rst_owner", owner, 0);
        chk("rst1_state", {busy1, me1, owner1, ack_a1, ack_b1}, 0);
        chk("rst1_data", {rd_a1, rd_b1, msel1, md1}, 0);

        for (int i = 0; i < 8; i++)
            run_txn(tbl[i].p, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].erd,
                    tbl[i].chg, tbl[i].nm);

        alt_test();
        rst_strobe_test();
        rand_test(800);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
